// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller sharing one BCD decoder.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [3:0]              bcd_out,
  input  logic [8:0]              seg_in,
  output logic [8:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYC - 1);
  localparam logic [DIV_WIDTH-1:0] SHOW_LAST  = DIV_WIDTH'(SCAN_DIV - 1);
  localparam logic [IW-1:0]        IDX_LAST   = IW'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [DIV_WIDTH-1:0]    timer, timer_n;
  logic [4*NUM_DIGITS-1:0] active, pending;
  logic                    pend_full, xfer, capture, accept, blank;
  logic [6:0]              seg7;
  logic                    unused_seg;
  assign unused_seg = &seg_in[8:7];
  assign load_ready = !pend_full;
  assign accept     = load_valid && !pend_full;
  assign bcd_out    = active[{idx, 2'b00} +: 4];
  assign dig_sel    = state == SHOW ? ~(NUM_DIGITS'(1) << idx) : '1;
  assign frame_done = state == SHOW && idx == IDX_LAST && timer == SHOW_LAST;
`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  run;
  // lz[i]: digit i and every digit above it are zero
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run   = run && active[4*i +: 4] == 4'd0;
      lz[i] = run;
    end
  end
  assign blank = idx != '0 && lz[idx] && !dp_mask[idx];
`else
  assign blank = 1'b0;
`endif
  assign seg7 = blank ? 7'h00 : bcd_out > 4'd9 ? 7'h40 : seg_in[6:0];
  always_comb begin
    state_n = state;
    idx_n   = idx;
    timer_n = timer + DIV_WIDTH'(1);
    xfer    = 1'b0;
    capture = 1'b0;
    if (!en) begin
      state_n = IDLE;
      idx_n   = '0;
      timer_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLANK;
          timer_n = '0;
          xfer    = 1'b1;
        end
        BLANK: if (timer == BLANK_LAST) begin
          state_n = SHOW;
          timer_n = '0;
          capture = 1'b1;
        end
        SHOW: if (timer == SHOW_LAST) begin
          state_n = BLANK;
          timer_n = '0;
          idx_n   = idx == IDX_LAST ? '0 : idx + IW'(1);
          xfer    = idx == IDX_LAST;
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          timer_n = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      timer     <= '0;
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      seg_out   <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      timer     <= timer_n;
      if (xfer && pend_full) active <= pending;
      if (accept) pending <= load_data;
      pend_full <= accept || (pend_full && !xfer);
      seg_out   <= state_n == IDLE ? 9'h000 : capture ? {dp_mask[idx], 1'b0, seg7} : seg_out;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl against a frame/slot arithmetic model.
module tb_seg_scan_ctrl;
  localparam int ND = 4, SD = 8, BC = 2, SLOT = SD + BC, FRAME = ND * SLOT;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, load_valid = 1'b0;
  logic        load_ready, frame_done;
  logic [15:0] load_data = '0;
  logic [3:0]  dp_mask = '0, bcd_out, dig_sel;
  logic [8:0]  seg_in, seg_out;
  logic [6:0]  dec_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
  typedef struct packed {logic [3:0] sel; logic [8:0] seg;} slot_t;
  slot_t       sb[$];
  int          errors = 0, checks = 0;
  bit          running = 0, m_full = 0;
  int          t = 0;
  logic [15:0] m_active = '0, m_pend = '0;

  assign seg_in = {2'b11, dec_tab[bcd_out]};
  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV_WIDTH(16), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .dp_mask(dp_mask), .bcd_out(bcd_out), .seg_in(seg_in),
    .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_seg(logic [15:0] act, int s, logic dpm);
    logic [3:0] d;
    logic [6:0] g;
    d = 4'(act >> (4 * s));
    g = d > 4'd9 ? 7'h40 : dec_tab[d];
`ifdef SEG_SCAN_LZB_EN
    if (s > 0 && (act >> (4 * s)) == 16'h0 && !dpm) g = 7'h00;
`endif
    return {dpm, 1'b0, g};
  endfunction

  // advances the model across one clock edge using the inputs held before it
  task automatic model_step();
    bit    acc;
    int    s;
    slot_t r;
    acc = load_valid && !m_full;
    s   = (t / SLOT) % ND;
    if (!running) begin
      if (en) begin
        running = 1;
        t = 0;
        if (m_full) begin m_active = m_pend; m_full = 0; end
      end
    end else if (!en) running = 0;
    else begin
      if (t % SLOT == BC - 1) begin
        r.sel = ~(4'b0001 << s);
        r.seg = exp_seg(m_active, s, dp_mask[s]);
        sb.push_back(r);
      end
      if (t % FRAME == FRAME - 1 && m_full) begin m_active = m_pend; m_full = 0; end
      t++;
    end
    if (acc) begin m_pend = load_data; m_full = 1; end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic load(logic [15:0] v);
    load_valid = 1'b1;
    load_data  = v;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wait_t(int p);
    for (int i = 0; i < FRAME && !(running && t % FRAME == p); i++) tick();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dig_sel", 32'(dig_sel), 32'hf);
    chk("rst_seg_out", 32'(seg_out), 32'h0);
    chk("rst_load_ready", 32'(load_ready), 32'h1);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    running = 0; t = 0; m_active = '0; m_pend = '0; m_full = 0;
    sb.delete();
    ticks(2);
    rst_n = 1'b1;
  endtask

  slot_t cur;
  bit    in_show = 0;
  int    show_len = 0;
  always @(negedge clk) begin : mon
    int         ph, s;
    logic [3:0] e_sel;
    if (!rst_n) begin
      in_show  = 0;
      show_len = 0;
    end else begin
      ph    = t % SLOT;
      s     = (t / SLOT) % ND;
      e_sel = (running && ph >= BC) ? ~(4'b0001 << s) : 4'hf;
      chk("dig_sel", 32'(dig_sel), 32'(e_sel));
      chk("frame_done", 32'(frame_done), 32'(running && t % FRAME == FRAME - 1));
      chk("load_ready", 32'(load_ready), 32'(!m_full));
      if (!running) chk("idle_seg", 32'(seg_out), 32'h0);
      else if (ph < BC) chk("blank_bcd", 32'(bcd_out), (32'(m_active) >> (4 * s)) & 32'hf);
      if (dig_sel != 4'hf) begin
        if (!in_show) begin
          in_show  = 1;
          show_len = 0;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL slot_unexpected: dig_sel %b seg_out %h with empty scoreboard", dig_sel, seg_out);
            cur.sel = 4'hf;
            cur.seg = 9'h0;
          end else cur = sb.pop_front();
        end
        show_len++;
        chk("slot_sel", 32'(dig_sel), 32'(cur.sel));
        chk("slot_seg", 32'(seg_out), 32'(cur.seg));
      end else if (in_show) begin
        in_show = 0;
        if (running) chk("slot_len", 32'(show_len), 32'(SD));
      end
    end
  end

  initial begin
    ticks(3);
    rst_n = 1'b1;
    ticks(2);
    load(16'h1234);
    ticks(2);
    en = 1'b1;
    ticks(2 * FRAME);
    wait_t(15);
    load(16'h5678);
    ticks(2 * FRAME);
    load(16'h00a0);
    ticks(2 * FRAME);
    dp_mask = 4'b0010;
    ticks(FRAME + 5);
    dp_mask = 4'b0000;
    wait_t(2 * SLOT + BC + 2);
    en = 1'b0;
    ticks(3);
    en = 1'b1;
    ticks(FRAME);
    load(16'h9876);
    wait_t(SLOT + BC + 3);
    async_reset();
    ticks(FRAME + 3);
    for (int i = 0; i < 1500; i++) begin
      load_valid = $urandom_range(0, 5) == 0;
      load_data  = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(0, 149) == 0) en = !en;
      tick();
    end
    load_valid = 1'b0;
    en = 1'b0;
    ticks(3);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
